rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port (a3/wd3/we3) between the pipeline writeback stage and a multi-cycle execution unit (mul/div) that returns results out of order with pipeline timing.
- Buffers multi-cycle results in a small FIFO and arbitrates them onto the write port.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against outstanding long-latency results.
- Sits between the writeback stage, the MDU result interface, decode hazard logic and the regfile.

Parameters:
- N, 5, register address width (2**N registers)
- M, 32, data width
- DEPTH, 2, MDU result FIFO depth (power of two, >=2)
- STARVE_MAX, 4, consecutive lost arbitration cycles before the MDU head is forced onto the write port

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wb_we  in  1  writeback stage write request
- wb_addr  in  N  writeback destination register
- wb_data  in  M  writeback data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept a result (= not full)
- mdu_addr  in  N  MDU destination register
- mdu_data  in  M  MDU result data
- issue_valid  in  1  decode issues an MDU op this cycle
- issue_addr  in  N  destination register of the issued MDU op
- chk_a1  in  N  decode source register 1
- chk_a2  in  N  decode source register 2
- chk_busy1  out  1  chk_a1 has an outstanding MDU result
- chk_busy2  out  1  chk_a2 has an outstanding MDU result
- stall_wb  out  1  writeback must hold its request this cycle
- rf_we3  out  1  regfile write enable
- rf_a3  out  N  regfile write address
- rf_wd3  out  M  regfile write data

Behaviour:
- Async reset, while rst_n=0:
  - FIFO empty; mdu_ready=1.
  - Starvation counter cleared to 0.
  - All pending bits cleared; chk_busy1/2=0.
  - stall_wb=0; rf_we3 follows the grant logic, so it is 0 unless wb_we=1.
- FIFO push: on posedge when mdu_valid && mdu_ready. mdu_ready = !full; no push-through when full, even if a pop occurs in the same cycle.
- Grant is combinational each cycle:
  - force = FIFO non-empty && cnt >= STARVE_MAX.
  - If force: MDU head granted; stall_wb = wb_we.
  - Else if wb_we: writeback granted.
  - Else if FIFO non-empty: MDU head granted.
  - Else: no grant.
- Write port drive:
  - rf_a3/rf_wd3 come from the granted source; rf_we3 = granted && addr != 0.
  - A grant to address 0 is still consumed (FIFO pop, or writeback completes) but does not write.
  - When nothing is granted, rf_a3/rf_wd3 = 0.
- FIFO pop: on posedge when the MDU head is granted.
- Starvation counter cnt (width clog2(STARVE_MAX+1)):
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise increments, saturating at STARVE_MAX.
- Scoreboard pending[2**N]:
  - Set on posedge when issue_valid && issue_addr != 0.
  - Cleared on posedge when an MDU head write to that register is granted.
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is always 0.
  - Issuing to an already-pending register is illegal; decode must stall on chk_busy first.
- Busy outputs:
  - chk_busyX = pending[chk_aX] && !(MDU head granted this cycle && head addr == chk_aX).
  - This matches the regfile's same-cycle write-through, so the dependent instruction reads the forwarded value.
- Latency:
  - MDU result to regfile write is 1 cycle minimum (push, then head granted the next cycle).
  - Worst case is STARVE_MAX+1 cycles per FIFO entry ahead.
- Writeback stall handshake:
  - When stall_wb=1, the pipeline holds wb_we/wb_addr/wb_data stable.
  - The held writeback is granted the next cycle unless force is asserted again.
  - Force is asserted again only if the FIFO refilled and starved again; cnt restarts from 0 after each grant.
- Reset mid-operation: FIFO contents and pending bits are discarded; no write is issued after deassertion until new requests arrive.

Test Plan:
- Reset, then wb_we=1, wb_addr=3, wb_data=0x11 -> same cycle rf_we3=1, rf_a3=3, rf_wd3=0x11; stall_wb=0.
- issue_valid with issue_addr=5 -> next cycle chk_a1=5 gives chk_busy1=1. Push MDU result (5, 0xAB) with wb_we=0 -> next cycle rf_we3=1, rf_a3=5, rf_wd3=0xAB and chk_busy1=0 in that same cycle; pending[5]=0 after.
- MDU result (7, 0x77) pushed while wb_we=1 held continuously:
  - Writeback is granted for 4 cycles while cnt counts 1..4.
  - 5th cycle: force=1, stall_wb=1, rf_a3=7, rf_wd3=0x77.
  - Following cycle: the held writeback is written.
- Push 2 results with no grants (wb_we=1) -> mdu_ready=0. A 3rd mdu_valid is not accepted and must be held until mdu_ready returns to 1.
- MDU result to register 0 -> FIFO pops, rf_we3=0. wb_addr=0 -> rf_we3=0. issue_addr=0 -> chk_busy stays 0.
- Reset asserted with 2 FIFO entries and pending[9]=1 -> immediately mdu_ready=1, chk_busy for reg 9 = 0, stall_wb=0; no MDU write after release.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - regfile write-port arbiter between writeback and a buffered MDU result FIFO
module rf_wport_arbiter #(
  parameter int N          = 5,
  parameter int M          = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wb_we,
  input  logic [N-1:0] wb_addr,
  input  logic [M-1:0] wb_data,
  input  logic         mdu_valid,
  output logic         mdu_ready,
  input  logic [N-1:0] mdu_addr,
  input  logic [M-1:0] mdu_data,
  input  logic         issue_valid,
  input  logic [N-1:0] issue_addr,
  input  logic [N-1:0] chk_a1,
  input  logic [N-1:0] chk_a2,
  output logic         chk_busy1,
  output logic         chk_busy2,
  output logic         stall_wb,
  output logic         rf_we3,
  output logic [N-1:0] rf_a3,
  output logic [M-1:0] rf_wd3
);

  localparam int NREG = 1 << N;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(STARVE_MAX + 1);

  logic [N-1:0]    q_addr [DEPTH];
  logic [M-1:0]    q_data [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   cnt;
  logic [NREG-1:0] pending, pending_nxt;

  logic         empty, full, push, pop, force_mdu;
  logic         head_grant, wb_grant;
  logic [N-1:0] head_addr;
  logic [M-1:0] head_data;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;
  assign pop       = head_grant;
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign force_mdu = !empty && (cnt >= CW'(STARVE_MAX));

  always_comb begin
    head_grant = 1'b0;
    wb_grant   = 1'b0;
    stall_wb   = 1'b0;
    if (force_mdu) begin
      head_grant = 1'b1;
      stall_wb   = wb_we;
    end else if (wb_we) begin
      wb_grant = 1'b1;
    end else if (!empty) begin
      head_grant = 1'b1;
    end
  end

  always_comb begin
    rf_a3  = '0;
    rf_wd3 = '0;
    if (head_grant) begin
      rf_a3  = head_addr;
      rf_wd3 = head_data;
    end else if (wb_grant) begin
      rf_a3  = wb_addr;
      rf_wd3 = wb_data;
    end
  end

  // Writes to r0 still consume the grant; they just never reach the regfile.
  assign rf_we3 = (head_grant || wb_grant) && (rf_a3 != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= mdu_addr;
      q_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (empty || head_grant) begin
      cnt <= '0;
    end else if (cnt < CW'(STARVE_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Set after clear so a same-cycle reissue to the retiring register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (head_grant) pending_nxt[head_addr] = 1'b0;
    if (issue_valid && (issue_addr != '0)) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign chk_busy1 = pending[chk_a1] && !(head_grant && (head_addr == chk_a1));
  assign chk_busy2 = pending[chk_a2] && !(head_grant && (head_addr == chk_a2));

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - self-checking bench for rf_wport_arbiter with a queue-based reference model
module tb_rf_wport_arbiter;

  localparam int N  = 5;
  localparam int M  = 32;
  localparam int DP = 2;
  localparam int SM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wb_we = 1'b0;
  logic [N-1:0] wb_addr = '0;
  logic [M-1:0] wb_data = '0;
  logic         mdu_valid = 1'b0;
  logic         mdu_ready;
  logic [N-1:0] mdu_addr = '0;
  logic [M-1:0] mdu_data = '0;
  logic         issue_valid = 1'b0;
  logic [N-1:0] issue_addr = '0;
  logic [N-1:0] chk_a1 = '0;
  logic [N-1:0] chk_a2 = '0;
  logic         chk_busy1, chk_busy2, stall_wb, rf_we3;
  logic [N-1:0] rf_a3;
  logic [M-1:0] rf_wd3;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.N(N), .M(M), .DEPTH(DP), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .stall_wb(stall_wb), .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [M-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   starve = 0;
  bit   pend[32];

  // Who owns the write port this cycle, from queue occupancy and starvation age.
  function automatic void decide(output bit hg, output bit wg, output bit st);
    int  sz  = rst_n ? mq.size() : 0;
    int  sv  = rst_n ? starve : 0;
    bit  frc = (sz > 0) && (sv >= SM);
    hg = frc || (!wb_we && sz > 0);
    wg = !frc && wb_we;
    st = frc && wb_we;
  endfunction

  function automatic bit exp_busy(input logic [N-1:0] a, input bit hg);
    if (!rst_n || !pend[a]) return 1'b0;
    if (hg && mq[0].a == a) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    bit hg, wg, st, ewe;
    logic [N-1:0] ea;
    logic [M-1:0] ed;
    @(negedge clk);
    decide(hg, wg, st);
    ea = '0;
    ed = '0;
    if (hg) begin
      ea = mq[0].a;
      ed = mq[0].d;
    end else if (wg) begin
      ea = wb_addr;
      ed = wb_data;
    end
    ewe = (hg || wg) && (ea != '0);
    chk("m_we3", 32'(rf_we3), 32'(ewe));
    chk("m_a3", 32'(rf_a3), 32'(ea));
    chk("m_wd3", rf_wd3, ed);
    chk("m_stall", 32'(stall_wb), 32'(st));
    chk("m_ready", 32'(mdu_ready), 32'(((rst_n ? mq.size() : 0) < DP)));
    chk("m_busy1", 32'(chk_busy1), 32'(exp_busy(chk_a1, hg)));
    chk("m_busy2", 32'(chk_busy2), 32'(exp_busy(chk_a2, hg)));
  end

  initial forever begin
    bit hg, wg, st, was_empty, do_push;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      starve = 0;
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      decide(hg, wg, st);
      was_empty = (mq.size() == 0);
      do_push   = mdu_valid && (mq.size() < DP);
      if (hg) begin
        pend[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      starve = (was_empty || hg) ? 0 : ((starve < SM) ? starve + 1 : SM);
      if (issue_valid && issue_addr != '0) pend[issue_addr] = 1'b1;
      if (do_push) mq.push_back('{a: mdu_addr, d: mdu_data});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int n;
    chk_a2 = 5'd7;
    mid();
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_stall", 32'(stall_wb), 32'd0);
    chk("rst_we3", 32'(rf_we3), 32'd0);
    chk("rst_busy1", 32'(chk_busy1), 32'd0);
    nxt();
    rst_n = 1'b1;

    // plain writeback goes straight through
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    mid();
    chk("wb_we3", 32'(rf_we3), 32'd1);
    chk("wb_a3", 32'(rf_a3), 32'd3);
    chk("wb_wd3", rf_wd3, 32'h11);
    chk("wb_stall", 32'(stall_wb), 32'd0);
    nxt();
    wb_we = 1'b0;

    // issue -> busy -> result retires with same-cycle busy drop
    issue_valid = 1'b1; issue_addr = 5'd5;
    nxt();
    issue_valid = 1'b0; chk_a1 = 5'd5;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'hAB;
    mid();
    chk("iss_busy1", 32'(chk_busy1), 32'd1);
    nxt();
    mdu_valid = 1'b0;
    mid();
    chk("mdu_we3", 32'(rf_we3), 32'd1);
    chk("mdu_a3", 32'(rf_a3), 32'd5);
    chk("mdu_wd3", rf_wd3, 32'hAB);
    chk("mdu_busy_fwd", 32'(chk_busy1), 32'd0);
    nxt();
    mid();
    chk("mdu_busy_after", 32'(chk_busy1), 32'd0);
    chk("mdu_idle_we3", 32'(rf_we3), 32'd0);
    nxt();

    // starvation: four writeback wins, then forced MDU write and held writeback
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h77;
    nxt();
    mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("starve_wb_a3", 32'(rf_a3), 32'd2);
      chk("starve_wb_stall", 32'(stall_wb), 32'd0);
      nxt();
    end
    mid();
    chk("force_stall", 32'(stall_wb), 32'd1);
    chk("force_a3", 32'(rf_a3), 32'd7);
    chk("force_wd3", rf_wd3, 32'h77);
    nxt();
    mid();
    chk("held_wb_a3", 32'(rf_a3), 32'd2);
    chk("held_wb_wd3", rf_wd3, 32'h22);
    chk("held_wb_stall", 32'(stall_wb), 32'd0);
    nxt();

    // FIFO fills while writeback keeps winning; third result waits for space
    wb_addr = 5'd6; wb_data = 32'h30;
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h88;
    nxt();
    mdu_addr = 5'd9; mdu_data = 32'h99;
    nxt();
    mdu_addr = 5'd10; mdu_data = 32'hAA;
    n = 0;
    mid();
    chk("full_ready", 32'(mdu_ready), 32'd0);
    while (!mdu_ready && n < 20) begin
      nxt();
      n++;
      mid();
    end
    chk("full_wait_cycles", 32'(n), 32'd4);
    nxt();
    mdu_valid = 1'b0;
    wb_we = 1'b0;
    for (int i = 0; i < 4; i++) nxt();

    // register 0 cases
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h55;
    nxt();
    mdu_valid = 1'b0;
    mid();
    chk("r0_mdu_we3", 32'(rf_we3), 32'd0);
    nxt();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h66;
    mid();
    chk("r0_wb_we3", 32'(rf_we3), 32'd0);
    nxt();
    wb_we = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    nxt();
    issue_valid = 1'b0; chk_a1 = 5'd0;
    mid();
    chk("r0_busy1", 32'(chk_busy1), 32'd0);
    nxt();

    // reset mid-operation discards FIFO and scoreboard
    issue_valid = 1'b1; issue_addr = 5'd9;
    nxt();
    issue_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
    nxt();
    mdu_addr = 5'd12; mdu_data = 32'h12;
    nxt();
    mdu_valid = 1'b0; chk_a1 = 5'd9;
    mid();
    chk("pre_rst_ready", 32'(mdu_ready), 32'd0);
    chk("pre_rst_busy1", 32'(chk_busy1), 32'd1);
    nxt();
    rst_n = 1'b0;
    mid();
    chk("mid_rst_ready", 32'(mdu_ready), 32'd1);
    chk("mid_rst_busy1", 32'(chk_busy1), 32'd0);
    chk("mid_rst_stall", 32'(stall_wb), 32'd0);
    nxt();
    rst_n = 1'b1;
    wb_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("post_rst_we3", 32'(rf_we3), 32'd0);
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
